// File: rtl/simon_pkg.sv
// Shared widths and helpers for the Simon pattern game (datapath and control).
package simon_pkg;

    localparam int unsigned PAT_W  = 4;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;

    localparam logic [ADDR_W-1:0] IDX_MAX = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_PATTERN = 2'd1,
        LED_MEM     = 2'd2
    } led_src_e;

    // True when exactly one switch is up.
    function automatic logic is_one_hot(input logic [PAT_W-1:0] p);
        return (p != '0) && ((p & (p - PAT_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/simon_pattern_mem.sv
// 64x4 pattern register file: synchronous write, combinational read, no reset.
module simon_pattern_mem
    import simon_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PAT_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PAT_W-1:0]  rdata
);

    logic [PAT_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/simon_datapath.sv
// Simon datapath: pattern store, playback/input counters, legality check and LED mux.
module simon_datapath
    import simon_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             level,
    input  logic [PAT_W-1:0] pattern,
    input  logic             m1,
    input  logic             m2,
    input  logic             m3,
    input  logic             m4,
    input  logic             count_ns,
    input  logic             count_i,
    input  logic             rst_i,
    input  logic             reset,
    output logic             legal,
    output logic             right_guess,
    output logic             i_eq_ns,
    output logic [PAT_W-1:0] pattern_leds
);

    logic [ADDR_W-1:0] r_ns;
    logic [ADDR_W-1:0] r_i;
    logic              r_level_q;

    logic              w_legal;
    logic              w_we;
    logic [PAT_W-1:0]  w_rdata;
    led_src_e          w_led_src;

    // Index counters and difficulty latch; game restart also samples the level switch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ns      <= '0;
            r_i       <= '0;
            r_level_q <= 1'b0;
        end else if (reset) begin
            r_ns      <= '0;
            r_i       <= '0;
            r_level_q <= level;
        end else begin
            if (rst_i) begin
                r_i <= '0;
            end else if (count_i) begin
                r_i <= r_i + ADDR_W'(1);
            end
            if (count_ns && (r_ns != IDX_MAX)) begin
                r_ns <= r_ns + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_legal = r_level_q ? (pattern != '0) : is_one_hot(pattern);
    end

    assign w_we = m1 & w_legal;

    simon_pattern_mem u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_ns),
        .wdata (pattern),
        .raddr (r_i),
        .rdata (w_rdata)
    );

    // Conflicting mode selects resolve m1 > m2 > m3 > m4.
    always_comb begin
        w_led_src = LED_OFF;
        if (m1) begin
            w_led_src = LED_PATTERN;
        end else if (m2) begin
            w_led_src = LED_MEM;
        end else if (m3) begin
            w_led_src = LED_PATTERN;
        end else if (m4) begin
            w_led_src = LED_MEM;
        end
    end

    always_comb begin
        pattern_leds = '0;
        case (w_led_src)
            LED_PATTERN: pattern_leds = pattern;
            LED_MEM:     pattern_leds = w_rdata;
            default:     pattern_leds = '0;
        endcase
    end

    assign legal       = w_legal;
    assign right_guess = (pattern == w_rdata);
    assign i_eq_ns     = (r_i == r_ns);

endmodule

// File: tb/tb_simon_datapath.sv
// Scoreboard bench for simon_datapath against a behavioural game model.
module tb_simon_datapath;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       level    = 1'b0;
    logic [3:0] pattern  = 4'd0;
    logic [3:0] modes    = 4'd0;
    logic       count_ns = 1'b0;
    logic       count_i  = 1'b0;
    logic       rst_i    = 1'b0;
    logic       reset    = 1'b0;

    logic       legal;
    logic       right_guess;
    logic       i_eq_ns;
    logic [3:0] pattern_leds;

    simon_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .level        (level),
        .pattern      (pattern),
        .m1           (modes[0]),
        .m2           (modes[1]),
        .m3           (modes[2]),
        .m4           (modes[3]),
        .count_ns     (count_ns),
        .count_i      (count_i),
        .rst_i        (rst_i),
        .reset        (reset),
        .legal        (legal),
        .right_guess  (right_guess),
        .i_eq_ns      (i_eq_ns),
        .pattern_leds (pattern_leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       legal;
        logic       ieq;
        logic       rg;
        logic       rg_v;
        logic [3:0] leds;
        logic       leds_v;
    } exp_t;

    exp_t sb[$];

    // Game model: plain arrays and integers.
    logic [3:0] mem_m [64];
    bit         known [64];
    int         ns_m  = 0;
    int         i_m   = 0;
    bit         lvl_m = 0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit legal_model();
        int ones = 0;
        for (int b = 0; b < 4; b++) ones += int'(pattern[b]);
        return lvl_m ? (pattern != 4'd0) : (ones == 1);
    endfunction

    function automatic exp_t predict(input string nm);
        exp_t e;
        e.name   = nm;
        e.legal  = legal_model();
        e.ieq    = (i_m == ns_m);
        e.rg_v   = known[i_m];
        e.rg     = (pattern == mem_m[i_m]);
        e.leds   = 4'd0;
        e.leds_v = 1'b1;
        if (modes[0]) begin
            e.leds = pattern;
        end else if (modes[1]) begin
            e.leds = mem_m[i_m]; e.leds_v = known[i_m];
        end else if (modes[2]) begin
            e.leds = pattern;
        end else if (modes[3]) begin
            e.leds = mem_m[i_m]; e.leds_v = known[i_m];
        end
        return e;
    endfunction

    task automatic check(input string nm, input string f, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, f, act, exp, $time);
        end
    endtask

    // Monitor: outputs are combinational, so sample each cycle mid-period.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, "legal", int'(legal), int'(e.legal));
            check(e.name, "i_eq_ns", int'(i_eq_ns), int'(e.ieq));
            if (e.rg_v)   check(e.name, "right_guess", int'(right_guess), int'(e.rg));
            if (e.leds_v) check(e.name, "pattern_leds", int'(pattern_leds), int'(e.leds));
        end
    end

    task automatic model_edge();
        bit lg;
        lg = legal_model();
        if (modes[0] && lg) begin
            mem_m[ns_m] = pattern;
            known[ns_m] = 1'b1;
        end
        if (rst) begin
            ns_m = 0; i_m = 0; lvl_m = 0;
        end else if (reset) begin
            ns_m = 0; i_m = 0; lvl_m = level;
        end else begin
            if (rst_i)        i_m = 0;
            else if (count_i) i_m = (i_m + 1) % 64;
            if (count_ns && ns_m < 63) ns_m = ns_m + 1;
        end
    endtask

    task automatic step(input string nm);
        sb.push_back(predict(nm));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [3:0] md, input logic [3:0] pat, input bit cns,
                         input bit ci, input bit ri, input bit rs, input bit lv);
        modes = md; pattern = pat; count_ns = cns; count_i = ci;
        rst_i = ri; reset = rs; level = lv;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time budget expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        #2 rst = 1'b1;
        @(posedge clk); #1;

        drive(4'b0100, 4'b0010, 0, 0, 0, 0, 0); step("rst_hold");
        drive(4'b0000, 4'b0000, 0, 0, 0, 0, 0); step("rst_idle");
        rst = 1'b0;

        // One-hot level: legal single bit is stored, two bits rejected.
        drive(4'b0001, 4'b0100, 0, 0, 0, 1, 0); step("wr_onehot");
        drive(4'b0001, 4'b0110, 0, 0, 0, 0, 0); step("wr_illegal");
        drive(4'b0010, 4'b0000, 0, 0, 0, 0, 0); step("mem0_kept");

        // Any-nonzero level.
        drive(4'b0000, 4'b0000, 0, 0, 0, 1, 1); step("lvl_load");
        drive(4'b0000, 4'b0110, 0, 0, 0, 0, 0); step("lvl1_legal");
        drive(4'b0000, 4'b0000, 0, 0, 0, 0, 0); step("lvl1_zero");

        // Store {1,2,4} then play back.
        drive(4'b0001, 4'd1, 1, 0, 0, 0, 0); step("fill0");
        drive(4'b0001, 4'd2, 1, 0, 0, 0, 0); step("fill1");
        drive(4'b0001, 4'd4, 0, 0, 0, 0, 0); step("fill2");
        drive(4'b0010, 4'd0, 0, 0, 1, 0, 0); step("pb_clr");
        drive(4'b0010, 4'd0, 0, 1, 0, 0, 0); step("pb0");
        drive(4'b0010, 4'd0, 0, 1, 0, 0, 0); step("pb1");
        drive(4'b0010, 4'd0, 0, 0, 0, 0, 0); step("pb2");

        // Repeat-mode guessing and rst_i priority over count_i.
        drive(4'b0100, 4'd0, 0, 0, 1, 0, 0); step("rp_clr");
        drive(4'b0100, 4'd0, 0, 1, 0, 0, 0); step("rp_inc");
        drive(4'b0100, 4'd2, 0, 0, 0, 0, 0); step("rp_hit");
        drive(4'b0100, 4'd8, 0, 0, 0, 0, 0); step("rp_miss");
        drive(4'b0100, 4'd8, 0, 1, 1, 0, 0); step("rp_both");
        drive(4'b0010, 4'd0, 0, 0, 0, 0, 0); step("rp_i0");

        // ns saturation and overwrite of the last slot.
        repeat (65) begin drive(4'b0000, 4'd0, 1, 0, 0, 0, 0); step("ns_sat"); end
        drive(4'b0001, 4'b1000, 0, 0, 0, 0, 0); step("wr63");
        drive(4'b0010, 4'd0, 0, 0, 1, 0, 0); step("walk_clr");
        repeat (63) begin drive(4'b0010, 4'd0, 0, 1, 0, 0, 0); step("walk"); end
        drive(4'b0010, 4'b1000, 0, 0, 0, 0, 0); step("rd63");
        drive(4'b1000, 4'd0, 0, 1, 0, 0, 0); step("i_wrap");
        drive(4'b1000, 4'd0, 0, 0, 0, 0, 0); step("i_wrapped");

        // Asynchronous rst in the middle of playback at i=5.
        drive(4'b0010, 4'd0, 0, 0, 1, 0, 0); step("ab_clr");
        repeat (5) begin drive(4'b0010, 4'd0, 0, 1, 0, 0, 0); step("ab_walk"); end
        drive(4'b0010, 4'd0, 0, 1, 0, 0, 0);
        #2 rst = 1'b1;
        ns_m = 0; i_m = 0; lvl_m = 0;
        step("ab_async");
        rst = 1'b0;
        drive(4'b0010, 4'd0, 0, 0, 0, 0, 0); step("ab_after");

        // Random traffic including conflicting selects.
        repeat (400) begin
            int r;
            logic [3:0] md;
            r = int'($urandom_range(0, 9));
            if (r < 2)      md = 4'd0;
            else if (r < 8) md = 4'(1 << $urandom_range(0, 3));
            else            md = 4'($urandom_range(0, 15));
            drive(md, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
            step("rnd");
        end

        drive(4'd0, 4'd0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("drain", "pending", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_datapath.md
SIMON_DATAPATH -- requirements
Module: simon_datapath

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port level, input, 1, difficulty select: 0 = one-hot only, 1 = any nonzero pattern.
REQ-004 SHALL have port pattern, input, 4, player switch pattern.
REQ-005 SHALL have ports m1, m2, m3 and m4, input, 1 each, one-hot mode selects from control: INPUT, PLAYBACK, REPEAT and DONE.
REQ-006 SHALL have ports count_ns, input, 1, increment ns.
REQ-007 SHALL have ports count_i and rst_i, input, 1 each, which increment and clear i respectively.
REQ-008 SHALL have port reset, input, 1, synchronous game restart from control.
REQ-009 SHALL have port legal, output, 1, current pattern acceptable for storage.
REQ-010 SHALL have port right_guess, output, 1, pattern equals mem[i].
REQ-011 SHALL have port i_eq_ns, output, 1, i == ns.
REQ-012 SHALL have port pattern_leds, output, 4, displayed pattern.

Function
REQ-013 SHALL hold a 64 x 4-bit pattern memory; write is synchronous and read is combinational.
REQ-014 SHALL hold ns (6-bit), the index of the last stored pattern, and i (6-bit), the playback/repeat index.
REQ-015 SHALL write pattern into mem[ns] on a clock edge where m1 & legal.
REQ-016 SHALL update i with priority reset > rst_i (i <= 0) > count_i (i <= i+1, wrapping 63 -> 0) > hold.
REQ-017 SHALL update ns with priority reset > count_ns (ns <= ns+1, saturating at 63) > hold; at ns=63, further INPUT writes overwrite mem[63].
REQ-018 SHALL load level_q from level on each edge where reset = 1, and hold level_q otherwise.
REQ-019 SHALL drive legal as follows: if level_q=0, 1 iff pattern has exactly one bit set; if level_q=1, 1 iff pattern != 0.
REQ-020 SHALL drive right_guess = (pattern == mem[i]) and i_eq_ns = (i == ns), both combinational with zero-cycle latency.
REQ-021 SHALL drive pattern_leds = pattern when m1 or m3, mem[i] when m2 or m4, and 4'b0000 when no select is set.
REQ-022 SHALL treat multiple asserted mode selects as a control error, resolved in priority m1 > m2 > m3 > m4.
REQ-023 SHALL have all outputs depend only on current inputs, i, ns, level_q and mem; there is no added pipeline delay.

Reset
REQ-024 SHALL on rst assertion asynchronously clear ns=0, i=0 and level_q=0; memory contents are not reset.
REQ-025 SHALL produce after rst the outputs i_eq_ns=1, legal per pattern one-hot rule, and pattern_leds per mode selects.
REQ-026 SHALL, if rst asserts mid-playback, abort the playback; i and ns read 0 from the next evaluation.

Structure
REQ-027 SHALL place PAT_W=4, ADDR_W=6 and DEPTH=64 in shared package simon_pkg, which is also used by the control block.
REQ-028 SHALL implement the memory as sub-module simon_pattern_mem (64x4 regfile, we/waddr/wdata, raddr/rdata async).
REQ-029 SHALL keep counters, legal and compare logic, and the LED mux in simon_datapath.

Verification
REQ-030 SHALL verify that with rst, then reset=1, level=0, m1=1 and pattern=4'b0100, legal=1 and mem[0] = 4'b0100 after one edge; pattern=4'b0110 gives legal=0 and no write.
REQ-031 SHALL verify that with level_q=1 and pattern=4'b0110, legal=1; with pattern=4'b0000, legal=0.
REQ-032 SHALL verify that with ns=2, mem={1,2,4}, m2=1 and count_i for 2 edges, pattern_leds sequence is 1, 2, 4 and i_eq_ns=1 on the third value.
REQ-033 SHALL verify that with m3=1, i=1, mem[1]=2 and pattern=2, right_guess=1; with pattern=8, right_guess=0; simultaneous count_i and rst_i clears i.
REQ-034 SHALL verify that with ns=63 and count_ns pulsed, ns stays 63; a subsequent m1 & legal write overwrites mem[63].
REQ-035 SHALL verify that asserting rst asynchronously mid-clock during m2 playback at i=5 sets i=0 and ns=0 before the next edge.
